// File: rtl/led_mode_sequencer_if.sv
// Button/display bundle between the board front end and the LED mode sequencer.
//   i_btn_mode/up/down : raw asynchronous push-buttons, active-high
//   i_lock             : freezes the mode FSM (only with LED_SEQ_LOCK_EN defined)
//   o_mode             : display mode, 0 sine, 1 up/down
//   o_incr_decr        : 01 increment, 10 decrement, 00 hold
//   o_mode_changed     : one-cycle pulse on every o_mode change
//   o_btn_db           : debounced levels {down, up, mode}
// master = board/stimulus side, slave = sequencer side.
interface led_mode_sequencer_if;
  logic       i_btn_mode;
  logic       i_btn_up;
  logic       i_btn_down;
`ifdef LED_SEQ_LOCK_EN
  logic       i_lock;
`endif
  logic       o_mode;
  logic [1:0] o_incr_decr;
  logic       o_mode_changed;
  logic [2:0] o_btn_db;

  modport master (
    output i_btn_mode,
    output i_btn_up,
    output i_btn_down,
`ifdef LED_SEQ_LOCK_EN
    output i_lock,
`endif
    input  o_mode,
    input  o_incr_decr,
    input  o_mode_changed,
    input  o_btn_db
  );

  modport slave (
    input  i_btn_mode,
    input  i_btn_up,
    input  i_btn_down,
`ifdef LED_SEQ_LOCK_EN
    input  i_lock,
`endif
    output o_mode,
    output o_incr_decr,
    output o_mode_changed,
    output o_btn_db
  );
endinterface

// File: rtl/led_mode_sequencer.sv
// LED mode sequencer: synchronizes and debounces the mode/up/down push-buttons and runs a
// two-state mode FSM (sine / up-down) that drives the display controller's mode select and
// increment/decrement command. In up/down mode an inactivity timeout reverts to sine.
//
// Ports:
//   i_clk   : system clock
//   i_rst_n : synchronous reset, active-low
//   bus     : led_mode_sequencer_if.slave (raw buttons in; mode, incr/decr, change pulse and
//             debounced levels out)
//
// Optional feature macro LED_SEQ_LOCK_EN: adds bus.i_lock. While high, mode presses are
// discarded, o_incr_decr is forced to 00, the idle counter is held cleared and the FSM state
// is frozen. Debouncing keeps running.
module led_mode_sequencer #(
  parameter int unsigned SYNC_STAGES         = 2,
  parameter int unsigned DEBOUNCE_CYCLES     = 1000000,
  parameter int unsigned IDLE_TIMEOUT_CYCLES = 500000000
) (
  input logic                 i_clk,
  input logic                 i_rst_n,
  led_mode_sequencer_if.slave bus
);

  localparam int unsigned DbW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned IdleW = (IDLE_TIMEOUT_CYCLES == 0) ? 1 :
                                  $clog2(IDLE_TIMEOUT_CYCLES + 1);
  localparam logic [DbW-1:0]   DbLast    = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [IdleW-1:0] IdleLast  = IdleW'(IDLE_TIMEOUT_CYCLES - 1);
  localparam bit               TimeoutEn = (IDLE_TIMEOUT_CYCLES != 0);

  // Button bit order throughout: {down, up, mode}
  localparam int unsigned BtnMode = 0;
  localparam int unsigned BtnUp   = 1;
  localparam int unsigned BtnDown = 2;

  typedef enum logic {StSine, StUpDown} state_e;

  logic lock;
`ifdef LED_SEQ_LOCK_EN
  assign lock = bus.i_lock;
`else
  assign lock = 1'b0;
`endif

  // ---------------------------------------------------------------------------------------
  // Synchronizer: plain flop chain per button
  // ---------------------------------------------------------------------------------------
  logic [2:0] btn_raw;
  logic [2:0] sync_q [SYNC_STAGES];
  logic [2:0] btn_sync;

  assign btn_raw  = {bus.i_btn_down, bus.i_btn_up, bus.i_btn_mode};
  assign btn_sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= btn_raw;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  // ---------------------------------------------------------------------------------------
  // Debounce: per-button counter of consecutive mismatching cycles
  // ---------------------------------------------------------------------------------------
  logic [2:0]          db_d, db_q;
  logic [2:0][DbW-1:0] db_cnt_d, db_cnt_q;

  always_comb begin
    db_d     = db_q;
    db_cnt_d = '0;
    for (int b = 0; b < 3; b++) begin
      if (btn_sync[b] != db_q[b]) begin
        // The last mismatching cycle flips the level; the counter returns to 0 either way
        if (db_cnt_q[b] == DbLast) begin
          db_d[b] = ~db_q[b];
        end else begin
          db_cnt_d[b] = db_cnt_q[b] + DbW'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      db_q     <= '0;
      db_cnt_q <= '0;
    end else begin
      db_q     <= db_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Mode FSM with registered outputs and idle timeout
  // ---------------------------------------------------------------------------------------
  state_e           state_q;
  logic             mode_prev_q;
  logic [1:0]       incr_decr_q;
  logic             mode_changed_q;
  logic [IdleW-1:0] idle_cnt_q;

  logic       mode_press;
  logic       idle_run;
  logic       timeout;
  logic [1:0] updown_cmd;

  // Presses during lock are dropped: mode_prev_q keeps tracking, so the edge is consumed
  assign mode_press = db_q[BtnMode] & ~mode_prev_q & ~lock;
  assign idle_run   = TimeoutEn && !lock && !db_q[BtnUp] && !db_q[BtnDown];
  assign timeout    = idle_run && (idle_cnt_q == IdleLast);
  assign updown_cmd = lock ? 2'b00 : {db_q[BtnDown] & ~db_q[BtnUp], db_q[BtnUp] & ~db_q[BtnDown]};

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q        <= StSine;
      mode_prev_q    <= 1'b0;
      incr_decr_q    <= 2'b00;
      mode_changed_q <= 1'b0;
      idle_cnt_q     <= '0;
    end else begin
      mode_prev_q    <= db_q[BtnMode];
      mode_changed_q <= 1'b0;
      unique case (state_q)
        StSine: begin
          idle_cnt_q  <= '0;
          incr_decr_q <= 2'b00;
          if (mode_press) begin
            state_q        <= StUpDown;
            mode_changed_q <= 1'b1;
            incr_decr_q    <= updown_cmd;
          end
        end
        StUpDown: begin
          // A press coinciding with timeout expiry is one transition, one pulse
          if (mode_press || timeout) begin
            state_q        <= StSine;
            mode_changed_q <= 1'b1;
            incr_decr_q    <= 2'b00;
            idle_cnt_q     <= '0;
          end else begin
            incr_decr_q <= updown_cmd;
            if (idle_run) begin
              idle_cnt_q <= idle_cnt_q + IdleW'(1);
            end else begin
              idle_cnt_q <= '0;
            end
          end
        end
        default: begin
          state_q     <= StSine;
          incr_decr_q <= 2'b00;
          idle_cnt_q  <= '0;
        end
      endcase
    end
  end

  assign bus.o_mode         = (state_q == StUpDown);
  assign bus.o_incr_decr    = incr_decr_q;
  assign bus.o_mode_changed = mode_changed_q;
  assign bus.o_btn_db       = db_q;

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Directed bench for led_mode_sequencer (SYNC_STAGES=2, DEBOUNCE_CYCLES=4,
// IDLE_TIMEOUT_CYCLES=20). A raw step shows on o_btn_db 6 edges later and on the FSM
// outputs 7 edges later; idle timeout fires 20 edges after debounced up/down both fall.
module tb_led_mode_sequencer;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  led_mode_sequencer_if bus ();

  led_mode_sequencer #(
    .SYNC_STAGES        (2),
    .DEBOUNCE_CYCLES    (4),
    .IDLE_TIMEOUT_CYCLES(20)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the last one
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n          = 1'b0;
    bus.i_btn_mode = 1'b0;
    bus.i_btn_up   = 1'b0;
    bus.i_btn_down = 1'b0;
`ifdef LED_SEQ_LOCK_EN
    bus.i_lock = 1'b0;
`endif
    tick(2);
    rst_n = 1'b1;

    // 1. Reset state, held while idle
    check("rst_mode", {3'b0, bus.o_mode}, 4'h0);
    check("rst_incr", {2'b0, bus.o_incr_decr}, 4'h0);
    check("rst_db", {1'b0, bus.o_btn_db}, 4'h0);
    check("rst_chg", {3'b0, bus.o_mode_changed}, 4'h0);
    for (int i = 0; i < 50; i++) begin
      tick(1);
      check("idle_outs", {bus.o_mode, bus.o_mode_changed, bus.o_incr_decr}, 4'h0);
      check("idle_db", {1'b0, bus.o_btn_db}, 4'h0);
    end

    // 2. Clean mode press: db at edge 6, mode/pulse at edge 7
    bus.i_btn_mode = 1'b1;
    tick(5);
    check("p1_db_e5", {1'b0, bus.o_btn_db}, 4'h0);
    tick(1);
    check("p1_db_e6", {1'b0, bus.o_btn_db}, 4'h1);
    check("p1_mode_e6", {3'b0, bus.o_mode}, 4'h0);
    check("p1_chg_e6", {3'b0, bus.o_mode_changed}, 4'h0);
    tick(1);
    check("p1_mode_e7", {3'b0, bus.o_mode}, 4'h1);
    check("p1_chg_e7", {3'b0, bus.o_mode_changed}, 4'h1);
    tick(1);
    check("p1_chg_e8", {3'b0, bus.o_mode_changed}, 4'h0);
    check("p1_mode_e8", {3'b0, bus.o_mode}, 4'h1);
    tick(2);
    bus.i_btn_mode = 1'b0;             // edge 10, held 10 cycles
    tick(7);                           // edge 17
    check("p1_rel_db", {1'b0, bus.o_btn_db}, 4'h0);
    check("p1_rel_mode", {3'b0, bus.o_mode}, 4'h1);
    bus.i_btn_mode = 1'b1;             // second press
    tick(6);                           // edge 23, before idle timeout at 27
    check("p2_db", {1'b0, bus.o_btn_db}, 4'h1);
    check("p2_mode_pre", {3'b0, bus.o_mode}, 4'h1);
    tick(1);
    check("p2_mode", {3'b0, bus.o_mode}, 4'h0);
    check("p2_chg", {3'b0, bus.o_mode_changed}, 4'h1);
    tick(1);
    check("p2_chg_off", {3'b0, bus.o_mode_changed}, 4'h0);
    bus.i_btn_mode = 1'b0;
    tick(8);

    // 3. Bounce shorter than the debounce window
    for (int i = 0; i < 20; i++) begin
      bus.i_btn_mode = ~bus.i_btn_mode;
      tick(1);
      check("bnc_db", {1'b0, bus.o_btn_db}, 4'h0);
      check("bnc_mode", {3'b0, bus.o_mode}, 4'h0);
      tick(1);
      check("bnc_db", {1'b0, bus.o_btn_db}, 4'h0);
      check("bnc_mode", {3'b0, bus.o_mode}, 4'h0);
    end
    bus.i_btn_mode = 1'b0;
    tick(8);
    check("bnc_end_db", {1'b0, bus.o_btn_db}, 4'h0);

    // 4. Up/down commands and idle timeout
    bus.i_btn_mode = 1'b1;
    tick(7);
    check("ud_enter", {3'b0, bus.o_mode}, 4'h1);
    bus.i_btn_mode = 1'b0;
    bus.i_btn_up   = 1'b1;
    tick(7);
    check("ud_up", {2'b0, bus.o_incr_decr}, 4'h1);
    bus.i_btn_down = 1'b1;
    tick(6);
    check("ud_both_pre", {2'b0, bus.o_incr_decr}, 4'h1);
    tick(1);
    check("ud_both", {2'b0, bus.o_incr_decr}, 4'h0);
    check("ud_both_db", {1'b0, bus.o_btn_db}, 4'h6);
    bus.i_btn_up = 1'b0;
    tick(7);
    check("ud_down", {2'b0, bus.o_incr_decr}, 4'h2);
    bus.i_btn_down = 1'b0;
    tick(7);
    check("ud_none", {2'b0, bus.o_incr_decr}, 4'h0);
    tick(18);                          // 25 edges after release
    check("to_pre", {3'b0, bus.o_mode}, 4'h1);
    tick(1);
    check("to_mode", {3'b0, bus.o_mode}, 4'h0);
    check("to_chg", {3'b0, bus.o_mode_changed}, 4'h1);
    tick(1);
    check("to_chg_off", {3'b0, bus.o_mode_changed}, 4'h0);

    // 5. Mode press while up held
    bus.i_btn_mode = 1'b1;
    tick(7);
    check("s5_enter", {3'b0, bus.o_mode}, 4'h1);
    bus.i_btn_mode = 1'b0;
    bus.i_btn_up   = 1'b1;
    tick(7);
    check("s5_up", {2'b0, bus.o_incr_decr}, 4'h1);
    bus.i_btn_mode = 1'b1;
    tick(6);
    check("s5_pre", {bus.o_mode, 1'b0, bus.o_incr_decr}, 4'h9);
    tick(1);
    check("s5_exit", {bus.o_mode, bus.o_mode_changed, bus.o_incr_decr}, 4'h4);
    tick(3);
    check("s5_hold", {bus.o_mode, 1'b0, bus.o_incr_decr}, 4'h0);
    bus.i_btn_mode = 1'b0;
    tick(8);

    // 6. Reset mid-hold with up still pressed
    bus.i_btn_mode = 1'b1;
    tick(7);
    check("s6_enter", {bus.o_mode, 1'b0, bus.o_incr_decr}, 4'h9);
    bus.i_btn_mode = 1'b0;
    tick(3);
    rst_n = 1'b0;
    tick(1);
    check("s6_rst_outs", {bus.o_mode, bus.o_mode_changed, bus.o_incr_decr}, 4'h0);
    check("s6_rst_db", {1'b0, bus.o_btn_db}, 4'h0);
    rst_n = 1'b1;
    tick(5);
    check("s6_db_e5", {1'b0, bus.o_btn_db}, 4'h0);
    tick(1);
    check("s6_db_e6", {1'b0, bus.o_btn_db}, 4'h2);
    check("s6_outs_e6", {bus.o_mode, bus.o_mode_changed, bus.o_incr_decr}, 4'h0);
    tick(1);
    check("s6_outs_e7", {bus.o_mode, bus.o_mode_changed, bus.o_incr_decr}, 4'h0);
    bus.i_btn_up = 1'b0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
